// File: rtl/alu_rs.sv
`default_nettype none
// ============================================================================
// Module   : alu_rs
// Purpose  : Reservation station feeding the integer ALU. Holds dispatched
//            instructions until both operands are available (captured from
//            dispatch or snooped off two result broadcast buses), then issues
//            the lowest-index ready entry with a registered payload.
// Ports    : clk, rst (async active-low), rdy (global enable), flush
//            disp_*  : dispatch request and instruction fields
//            cdb0_* / cdb1_* : result broadcast buses (cdb0 has priority)
//            rs_full : all entries busy (combinational)
//            RS_sgn, RS_opcode, lhs, rhs, imm, pc, ROB_entry : issue payload
// Revision : 1.0  initial release
// ============================================================================
module alu_rs #(
   parameter int RS_SIZE = 8,
   parameter int TAG_W   = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             rdy,
   input  logic             flush,
   input  logic             disp_sgn,
   input  logic [5:0]       disp_opcode,
   input  logic [31:0]      disp_Vj,
   input  logic [31:0]      disp_Vk,
   input  logic             disp_Qj_vld,
   input  logic             disp_Qk_vld,
   input  logic [TAG_W-1:0] disp_Qj,
   input  logic [TAG_W-1:0] disp_Qk,
   input  logic [31:0]      disp_imm,
   input  logic [31:0]      disp_pc,
   input  logic [TAG_W-1:0] disp_rob,
   input  logic             cdb0_sgn,
   input  logic [TAG_W-1:0] cdb0_tag,
   input  logic [31:0]      cdb0_val,
   input  logic             cdb1_sgn,
   input  logic [TAG_W-1:0] cdb1_tag,
   input  logic [31:0]      cdb1_val,
   output logic             rs_full,
   output logic             RS_sgn,
   output logic [5:0]       RS_opcode,
   output logic [31:0]      lhs,
   output logic [31:0]      rhs,
   output logic [31:0]      imm,
   output logic [31:0]      pc,
   output logic [TAG_W-1:0] ROB_entry
);

   localparam int C_IDX_W = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;

   // ---------------------------------------------------------------- entries
   logic [RS_SIZE-1:0] busy_q,   busy_d;
   logic [RS_SIZE-1:0] qj_vld_q, qj_vld_d;
   logic [RS_SIZE-1:0] qk_vld_q, qk_vld_d;
   logic [5:0]         op_q  [RS_SIZE];
   logic [5:0]         op_d  [RS_SIZE];
   logic [31:0]        vj_q  [RS_SIZE];
   logic [31:0]        vj_d  [RS_SIZE];
   logic [31:0]        vk_q  [RS_SIZE];
   logic [31:0]        vk_d  [RS_SIZE];
   logic [TAG_W-1:0]   qj_q  [RS_SIZE];
   logic [TAG_W-1:0]   qj_d  [RS_SIZE];
   logic [TAG_W-1:0]   qk_q  [RS_SIZE];
   logic [TAG_W-1:0]   qk_d  [RS_SIZE];
   logic [31:0]        imm_q [RS_SIZE];
   logic [31:0]        imm_d [RS_SIZE];
   logic [31:0]        pc_q  [RS_SIZE];
   logic [31:0]        pc_d  [RS_SIZE];
   logic [TAG_W-1:0]   rob_q [RS_SIZE];
   logic [TAG_W-1:0]   rob_d [RS_SIZE];

   // ---------------------------------------------------------- issue payload
   logic             rs_sgn_q,    rs_sgn_d;
   logic [5:0]       rs_op_q,     rs_op_d;
   logic [31:0]      lhs_q,       lhs_d;
   logic [31:0]      rhs_q,       rhs_d;
   logic [31:0]      out_imm_q,   out_imm_d;
   logic [31:0]      out_pc_q,    out_pc_d;
   logic [TAG_W-1:0] rob_entry_q, rob_entry_d;

   // ------------------------------------------------------ select helpers
   logic [RS_SIZE-1:0] w_ready;
   logic               w_free_found;
   logic [C_IDX_W-1:0] w_free_idx;
   logic               w_sel_found;
   logic [C_IDX_W-1:0] w_sel_idx;

   assign rs_full = &busy_q;
   assign w_ready = busy_q & ~qj_vld_q & ~qk_vld_q;

   always_comb begin
      w_free_found = 1'b0;
      w_free_idx   = '0;
      w_sel_found  = 1'b0;
      w_sel_idx    = '0;
      for (int i = 0; i < RS_SIZE; i++) begin
         if (!busy_q[i] && !w_free_found) begin
            w_free_found = 1'b1;
            w_free_idx   = C_IDX_W'(i);
         end
         if (w_ready[i] && !w_sel_found) begin
            w_sel_found = 1'b1;
            w_sel_idx   = C_IDX_W'(i);
         end
      end
   end

   // -------------------------------------------------------- next state
   always_comb begin
      busy_d      = busy_q;
      qj_vld_d    = qj_vld_q;
      qk_vld_d    = qk_vld_q;
      op_d        = op_q;
      vj_d        = vj_q;
      vk_d        = vk_q;
      qj_d        = qj_q;
      qk_d        = qk_q;
      imm_d       = imm_q;
      pc_d        = pc_q;
      rob_d       = rob_q;
      rs_sgn_d    = rs_sgn_q;
      rs_op_d     = rs_op_q;
      lhs_d       = lhs_q;
      rhs_d       = rhs_q;
      out_imm_d   = out_imm_q;
      out_pc_d    = out_pc_q;
      rob_entry_d = rob_entry_q;

      if (rdy) begin
         if (flush) begin
            busy_d   = '0;
            rs_sgn_d = 1'b0;
         end else begin
            // Snoop both buses; cdb0 is checked first so it wins a tag tie.
            for (int i = 0; i < RS_SIZE; i++) begin
               if (busy_q[i] && qj_vld_q[i]) begin
                  if (cdb0_sgn && cdb0_tag == qj_q[i]) begin
                     vj_d[i]     = cdb0_val;
                     qj_vld_d[i] = 1'b0;
                  end else if (cdb1_sgn && cdb1_tag == qj_q[i]) begin
                     vj_d[i]     = cdb1_val;
                     qj_vld_d[i] = 1'b0;
                  end
               end
               if (busy_q[i] && qk_vld_q[i]) begin
                  if (cdb0_sgn && cdb0_tag == qk_q[i]) begin
                     vk_d[i]     = cdb0_val;
                     qk_vld_d[i] = 1'b0;
                  end else if (cdb1_sgn && cdb1_tag == qk_q[i]) begin
                     vk_d[i]     = cdb1_val;
                     qk_vld_d[i] = 1'b0;
                  end
               end
            end

            // Issue from pre-edge state; payload holds when nothing is ready.
            rs_sgn_d = w_sel_found;
            if (w_sel_found) begin
               rs_op_d           = op_q[w_sel_idx];
               lhs_d             = vj_q[w_sel_idx];
               rhs_d             = vk_q[w_sel_idx];
               out_imm_d         = imm_q[w_sel_idx];
               out_pc_d          = pc_q[w_sel_idx];
               rob_entry_d       = rob_q[w_sel_idx];
               busy_d[w_sel_idx] = 1'b0;
            end

            // Dispatch into the lowest free slot (never the issuing slot,
            // since that one is busy in pre-edge state).
            if (disp_sgn && !rs_full) begin
               busy_d[w_free_idx] = 1'b1;
               op_d[w_free_idx]   = disp_opcode;
               imm_d[w_free_idx]  = disp_imm;
               pc_d[w_free_idx]   = disp_pc;
               rob_d[w_free_idx]  = disp_rob;
               qj_d[w_free_idx]   = disp_Qj;
               qk_d[w_free_idx]   = disp_Qk;
               vj_d[w_free_idx]     = disp_Vj;
               qj_vld_d[w_free_idx] = disp_Qj_vld;
               if (disp_Qj_vld) begin
                  if (cdb0_sgn && cdb0_tag == disp_Qj) begin
                     vj_d[w_free_idx]     = cdb0_val;
                     qj_vld_d[w_free_idx] = 1'b0;
                  end else if (cdb1_sgn && cdb1_tag == disp_Qj) begin
                     vj_d[w_free_idx]     = cdb1_val;
                     qj_vld_d[w_free_idx] = 1'b0;
                  end
               end
               vk_d[w_free_idx]     = disp_Vk;
               qk_vld_d[w_free_idx] = disp_Qk_vld;
               if (disp_Qk_vld) begin
                  if (cdb0_sgn && cdb0_tag == disp_Qk) begin
                     vk_d[w_free_idx]     = cdb0_val;
                     qk_vld_d[w_free_idx] = 1'b0;
                  end else if (cdb1_sgn && cdb1_tag == disp_Qk) begin
                     vk_d[w_free_idx]     = cdb1_val;
                     qk_vld_d[w_free_idx] = 1'b0;
                  end
               end
            end
         end
      end
   end

   // -------------------------------------------------------- registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         busy_q      <= '0;
         qj_vld_q    <= '0;
         qk_vld_q    <= '0;
         for (int i = 0; i < RS_SIZE; i++) begin
            op_q[i]  <= '0;
            vj_q[i]  <= '0;
            vk_q[i]  <= '0;
            qj_q[i]  <= '0;
            qk_q[i]  <= '0;
            imm_q[i] <= '0;
            pc_q[i]  <= '0;
            rob_q[i] <= '0;
         end
         rs_sgn_q    <= 1'b0;
         rs_op_q     <= '0;
         lhs_q       <= '0;
         rhs_q       <= '0;
         out_imm_q   <= '0;
         out_pc_q    <= '0;
         rob_entry_q <= '0;
      end else begin
         busy_q      <= busy_d;
         qj_vld_q    <= qj_vld_d;
         qk_vld_q    <= qk_vld_d;
         op_q        <= op_d;
         vj_q        <= vj_d;
         vk_q        <= vk_d;
         qj_q        <= qj_d;
         qk_q        <= qk_d;
         imm_q       <= imm_d;
         pc_q        <= pc_d;
         rob_q       <= rob_d;
         rs_sgn_q    <= rs_sgn_d;
         rs_op_q     <= rs_op_d;
         lhs_q       <= lhs_d;
         rhs_q       <= rhs_d;
         out_imm_q   <= out_imm_d;
         out_pc_q    <= out_pc_d;
         rob_entry_q <= rob_entry_d;
      end
   end

   assign RS_sgn    = rs_sgn_q;
   assign RS_opcode = rs_op_q;
   assign lhs       = lhs_q;
   assign rhs       = rhs_q;
   assign imm       = out_imm_q;
   assign pc        = out_pc_q;
   assign ROB_entry = rob_entry_q;

endmodule
`default_nettype wire

// File: doc/alu_rs.md
ALU_RS -- requirements
Module: alu_rs

Interface
REQ-001 SHALL have parameter RS_SIZE, default 8, number of reservation-station entries (power of two, 2..16).
REQ-002 SHALL have parameter TAG_W, default 4, ROB tag width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 rdy  input  1  global enable; low freezes all state.
REQ-006 flush  input  1  misprediction clear.
REQ-007 disp_sgn  input  1  dispatch request.
REQ-008 disp_opcode  input  6  internal opcode code.
REQ-009 disp_Vj, disp_Vk  input  32 each  operand values when ready.
REQ-010 disp_Qj_vld, disp_Qk_vld  input  1 each  high = operand still waits on a ROB tag.
REQ-011 disp_Qj, disp_Qk  input  TAG_W each  producer tags.
REQ-012 disp_imm, disp_pc  input  32 each  immediate, instruction pc.
REQ-013 disp_rob  input  TAG_W  destination ROB entry.
REQ-014 cdb0_sgn/cdb0_tag/cdb0_val, cdb1_sgn/cdb1_tag/cdb1_val  input  1/TAG_W/32  two result broadcast buses (ALU, load-store).
REQ-015 rs_full  output  1  no free entry.
REQ-016 RS_sgn  output  1  issue valid to ALU, one-cycle pulse per instruction.
REQ-017 RS_opcode  output  6; lhs, rhs, imm, pc  output  32 each; ROB_entry  output  TAG_W  registered issue payload.

Function
REQ-018 Each entry SHALL hold busy, opcode, Vj, Vk, Qj_vld, Qj, Qk_vld, Qk, imm, pc, rob.
REQ-019 rs_full SHALL be combinational, high iff all RS_SIZE entries busy; a freeing issue in the same cycle SHALL NOT lower it.
REQ-020 On edge with rst high, rdy high, flush low, disp_sgn high, rs_full low: lowest-index non-busy entry SHALL be written and set busy.
REQ-021 disp_sgn while rs_full high SHALL be ignored (dispatcher guarantees no drop).
REQ-022 Dispatch forwarding: if disp_Qx_vld high and a cdbN_sgn is high with cdbN_tag == disp_Qx in the same cycle, entry SHALL store cdbN_val and Qx_vld = 0.
REQ-023 Snoop: every busy entry with Qx_vld high and matching cdbN_tag under cdbN_sgn SHALL capture cdbN_val and clear Qx_vld at the edge; both operands may clear from different buses in one cycle.
REQ-024 If both buses carry the same tag, cdb0 SHALL win.
REQ-025 Select: each cycle the lowest-index busy entry with Qj_vld=0 and Qk_vld=0, evaluated on pre-edge state, SHALL be issued: payload registered to outputs, RS_sgn=1, entry busy cleared.
REQ-026 Issue payload mapping: lhs=Vj, rhs=Vk, imm, pc, RS_opcode, ROB_entry=rob.
REQ-027 No ready entry: RS_sgn SHALL be 0 next cycle; payload outputs hold last values.
REQ-028 Latency: entry dispatched ready at edge N SHALL be issuable at edge N+1 earliest (RS_sgn high during cycle after N+1); entry woken by CDB at edge N likewise at N+1.
REQ-029 At most one issue and one dispatch per cycle; both may occur in the same cycle on different entries.
REQ-030 flush high at an edge (rdy high) SHALL clear all busy bits and RS_sgn; dispatch and issue in that cycle SHALL be discarded.
REQ-031 rdy low SHALL hold all entries and outputs unchanged, including RS_sgn.
REQ-032 Tag compare SHALL be full TAG_W width; tag 0 is a valid tag.

Reset
REQ-033 rst low SHALL immediately clear all busy bits, RS_sgn, and set RS_opcode, lhs, rhs, imm, pc, ROB_entry to 0, regardless of clk or rdy.
REQ-034 Reset mid-operation SHALL discard all entries; first dispatch after rst rises behaves as from empty.

Verification
REQ-035 Ready dispatch: opcode ADD, Vj=5, Vk=7, rob=3, both ready -> next cycle RS_sgn=1, lhs=5, rhs=7, ROB_entry=3, one pulse only.
REQ-036 Wakeup: dispatch Qj=2 pending, Vk=1; cdb1_sgn tag=2 val=0x10 two cycles later -> issue one cycle after broadcast with lhs=0x10.
REQ-037 Same-cycle forwarding: dispatch Qk=6 while cdb0 tag=6 val=0xAB -> issue next cycle with rhs=0xAB.
REQ-038 Fill: 8 dispatches all waiting on tag 9 -> rs_full=1, 9th dispatch ignored; cdb0 tag 9 -> entries issue in index order 0..7 on 8 consecutive cycles, rs_full drops after first issue edge.
REQ-039 Flush: 3 busy entries, flush with concurrent disp_sgn -> all empty, RS_sgn=0, rs_full=0, no later issue.
REQ-040 Async reset: rst low mid-cycle with RS_sgn=1 -> RS_sgn and payload 0 before next edge; rdy low for 4 cycles with ready entry -> no issue until rdy returns.
